// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM states, key codes and ALU op encodings for the calculator controller
package calc_pkg;
    localparam int BCD_W = 4;
    typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, RESULT, BROWSE, ERROR} state_t;
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_BSP = 4'hF;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    function automatic logic is_op(input logic [3:0] k);
        return k >= KEY_ADD && k <= KEY_DIV;
    endfunction
    function automatic logic [1:0] key_op(input logic [3:0] k);
        return k == KEY_ADD ? OP_ADD : k == KEY_SUB ? OP_SUB : k == KEY_MUL ? OP_MUL : OP_DIV;
    endfunction
endpackage

// File: rtl/calc_hist.sv
// calc_hist: circular result history; the browse cursor counts back from the newest entry
module calc_hist #(
    parameter int DEPTH = 8,
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   brs,
    input  logic                   older,
    input  logic                   newer,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, idx_q, idx_d;
    logic [AW:0] cnt_q, cnt_d;
    always_comb begin
        wp_d = push ? wp_q + 1'b1 : wp_q;
        cnt_d = push && cnt_q != FULL ? cnt_q + 1'b1 : cnt_q;
        idx_d = brs ? '0 :
                older && {1'b0, idx_q} + 1'b1 < cnt_q ? idx_q + 1'b1 :
                newer && idx_q != '0 ? idx_q - 1'b1 : idx_q;
    end
    assign rdata = mem_q[wp_q - 1'b1 - idx_q];
    assign count = cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            wp_q <= wp_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wdata;
    end
endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: calculator sequencer - BCD operand entry, ALU launch with timeout, result history browse
module calc_ctrl import calc_pkg::*; #(
    parameter int DIGITS = 4,
    parameter int HIST_DEPTH = 8,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_en,
    input  logic [3:0]                  key_num,
    input  logic                        equal,
    input  logic                        save,
    input  logic                        up,
    input  logic                        down,
    output logic                        alu_start,
    output logic [1:0]                  alu_op,
    output logic [4*DIGITS-1:0]         alu_a,
    output logic [4*DIGITS-1:0]         alu_b,
    input  logic                        alu_done,
    input  logic [4*DIGITS-1:0]         alu_result,
    input  logic                        alu_err,
    output logic [4*DIGITS-1:0]         disp_val,
    output logic                        disp_err,
    output logic [$clog2(HIST_DEPTH):0] hist_cnt
);
    localparam int W = BCD_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);
    localparam logic [TW-1:0] TMAX = TW'(ALU_TIMEOUT);
    state_t state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, cur, ed, hist_val;
    logic [1:0] op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d, ed_cnt;
    logic [TW-1:0] tmo_q, tmo_d;
    logic start_q, start_d;
    logic clr, eq, key, sv, u, dn, is_dig, has_hist, push, brs, older, newer;
    assign clr = key_en && key_num == KEY_CLR;
    assign eq = equal && !clr;
    assign key = key_en && !clr && !equal;
    assign sv = save && !key_en && !equal;
    assign u = up && !save && !key_en && !equal;
    assign dn = down && !up && !save && !key_en && !equal;
    assign is_dig = key_num <= 4'd9;
    assign has_hist = hist_cnt != '0;
    assign cur = state_q == ENTER_B ? b_q : a_q;
    assign ed = key_num == KEY_BSP ? cur >> BCD_W : cnt_q != FULL ? {cur[W-BCD_W-1:0], key_num} : cur;
    assign ed_cnt = key_num == KEY_BSP ? (cnt_q == '0 ? '0 : cnt_q - 1'b1) : cnt_q != FULL ? cnt_q + 1'b1 : cnt_q;
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        op_d = op_q;
        cnt_d = cnt_q;
        res_d = res_q;
        tmo_d = '0;
        push = 1'b0;
        brs = 1'b0;
        older = 1'b0;
        newer = 1'b0;
        if (clr && state_q != EXEC) begin
            state_d = ENTER_A;
            a_d = '0;
            b_d = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                ENTER_A, ENTER_B: begin
                    if (eq && state_q == ENTER_B) state_d = EXEC;
                    else if (key && is_op(key_num)) begin
                        op_d = key_op(key_num);
                        if (state_q == ENTER_A) begin
                            b_d = '0;
                            cnt_d = '0;
                            state_d = ENTER_B;
                        end
                    end else if (key) begin
                        if (state_q == ENTER_B) b_d = ed;
                        else a_d = ed;
                        cnt_d = ed_cnt;
                    end else if ((u || dn) && state_q == ENTER_A && has_hist) begin
                        brs = 1'b1;
                        state_d = BROWSE;
                    end
                end
                EXEC: begin
                    tmo_d = tmo_q + 1'b1;
                    if (alu_done) begin
                        res_d = alu_result;
                        state_d = alu_err ? ERROR : RESULT;
                    end else if (tmo_q == TMAX) state_d = ERROR;
                end
                RESULT: begin
                    if (key && is_op(key_num)) begin
                        a_d = res_q;
                        b_d = '0;
                        cnt_d = '0;
                        op_d = key_op(key_num);
                        state_d = ENTER_B;
                    end else if (key && is_dig) begin
                        a_d = W'(key_num);
                        cnt_d = CW'(1);
                        state_d = ENTER_A;
                    end else if (sv) push = 1'b1;
                    else if ((u || dn) && has_hist) begin
                        brs = 1'b1;
                        state_d = BROWSE;
                    end
                end
                BROWSE: begin
                    if (eq) begin
                        a_d = hist_val;
                        cnt_d = FULL;
                        state_d = ENTER_A;
                    end else if (u) older = 1'b1;
                    else if (dn) newer = 1'b1;
                end
                default: ;
            endcase
        end
        start_d = state_d == EXEC && state_q != EXEC;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ENTER_A;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            op_q <= '0;
            cnt_q <= '0;
            tmo_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            res_q <= res_d;
            op_q <= op_d;
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
            start_q <= start_d;
        end
    end
    calc_hist #(.DEPTH(HIST_DEPTH), .W(W)) u_hist (
        .clk(clk),
        .rst(rst),
        .push(push),
        .wdata(res_q),
        .brs(brs),
        .older(older),
        .newer(newer),
        .rdata(hist_val),
        .count(hist_cnt)
    );
    assign alu_start = start_q;
    assign alu_op = op_q;
    assign alu_a = a_q;
    assign alu_b = b_q;
    assign disp_err = state_q == ERROR;
    assign disp_val = state_q == ENTER_A || state_q == EXEC ? a_q :
                      state_q == ENTER_B ? b_q :
                      state_q == RESULT ? res_q :
                      state_q == BROWSE ? hist_val : '0;
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed stimulus with a launch scoreboard for calc_ctrl
module tb_calc_ctrl;
    logic clk = 0, rst = 0, key_en = 0, equal = 0, save = 0, up = 0, down = 0;
    logic alu_done = 0, alu_err = 0;
    logic [3:0] key_num = 0;
    logic [15:0] alu_result = 0;
    logic alu_start, disp_err;
    logic [1:0] alu_op;
    logic [15:0] alu_a, alu_b, disp_val;
    logic [3:0] hist_cnt;
    int n_chk = 0, n_fail = 0;
    typedef struct {logic [15:0] a; logic [15:0] b; logic [1:0] op;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    logic start_prev = 0;
    localparam logic [3:0] EQ = 4'b1000, SV = 4'b0100, UP = 4'b0010, DN = 4'b0001;

    always #5 clk = ~clk;

    calc_ctrl dut (
        .clk(clk), .rst(rst), .key_en(key_en), .key_num(key_num),
        .equal(equal), .save(save), .up(up), .down(down),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .disp_val(disp_val), .disp_err(disp_err), .hist_cnt(hist_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_en = 1; key_num = k;
        @(negedge clk);
        key_en = 0;
    endtask

    task automatic keys(input logic [31:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) press(seq[4*i +: 4]);
    endtask

    task automatic btn(input logic [3:0] b);
        {equal, save, up, down} = b;
        @(negedge clk);
        {equal, save, up, down} = 4'b0;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input int dly, input logic [15:0] res, input logic err);
        exp_q.push_back('{a, b, op});
        btn(EQ);
        chk("start_latency", alu_start, 1);
        chk("exec_disp", disp_val, a);
        repeat (dly) @(negedge clk);
        alu_done = 1; alu_result = res; alu_err = err;
        @(negedge clk);
        alu_done = 0; alu_err = 0;
    endtask

    always @(negedge clk) begin
        if (alu_start) begin
            chk("start_width", start_prev, 0);
            chk("start_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                chk("alu_op", alu_op, e.op);
            end
        end
        start_prev <= alu_start;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_start", alu_start, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_disp", disp_val, 0);
        chk("rst_err", disp_err, 0);
        chk("rst_hist", hist_cnt, 0);
        rst = 1;
        @(negedge clk);
        btn(UP);
        chk("up_empty_ignored", disp_val, 0);
        press(4'h5);
        chk("digit_after_up", disp_val, 16'h0005);
        press(4'hE);
        keys(32'h12, 2);
        chk("a_entry", disp_val, 16'h0012);
        press(4'hA);
        chk("b_cleared", disp_val, 0);
        keys(32'h34, 2);
        chk("b_entry", disp_val, 16'h0034);
        run(16'h0012, 16'h0034, 2'd0, 0, 16'h0046, 0);
        chk("result_disp", disp_val, 16'h0046);
        chk("result_err", disp_err, 0);
        press(4'hC);
        chk("chain_b_clear", disp_val, 0);
        press(4'h2);
        run(16'h0046, 16'h0002, 2'd2, 3, 16'h0092, 0);
        chk("chain_result", disp_val, 16'h0092);
        press(4'h7);
        chk("result_digit", disp_val, 16'h0007);
        press(4'hE);
        keys(32'h98765, 5);
        chk("digit_limit", disp_val, 16'h9876);
        press(4'hF);
        chk("backspace", disp_val, 16'h0987);
        press(4'h5);
        chk("after_bsp", disp_val, 16'h9875);
        press(4'hE);
        keys(32'h7B2, 3);
        exp_q.push_back('{16'h0007, 16'h0002, 2'd1});
        btn(EQ);
        cyc = 0;
        while (!disp_err && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycles", cyc, 65);
        chk("timeout_disp", disp_val, 0);
        press(4'h5);
        chk("error_digit_ignored", disp_val, 0);
        chk("error_holds", disp_err, 1);
        press(4'hE);
        chk("clear_error", disp_err, 0);
        chk("clear_disp", disp_val, 0);
        keys(32'h1A1, 3);
        run(16'h0001, 16'h0001, 2'd0, 64, 16'h0002, 0);
        chk("done_at_timeout_err", disp_err, 0);
        chk("done_at_timeout_val", disp_val, 16'h0002);
        press(4'hE);
        keys(32'h1A2, 3);
        key_en = 1; key_num = 4'hE; equal = 1;
        @(negedge clk);
        key_en = 0; equal = 0;
        chk("clr_eq_disp", disp_val, 0);
        chk("clr_eq_nostart", alu_start, 0);
        btn(EQ);
        chk("eq_in_enter_a", alu_start, 0);
        press(4'h3);
        chk("after_clr_eq", disp_val, 16'h0003);
        press(4'hE);
        for (int v = 1; v <= 9; v++) begin
            keys({20'h0, 4'(v), 8'hA0}, 3);
            run(16'(v), 16'h0000, 2'd0, 0, 16'(v), 0);
            btn(SV);
        end
        chk("hist_full", hist_cnt, 8);
        btn(UP);
        chk("browse_newest", disp_val, 16'h0009);
        repeat (7) btn(UP);
        chk("browse_oldest", disp_val, 16'h0002);
        btn(UP);
        chk("browse_sat", disp_val, 16'h0002);
        btn(DN);
        chk("browse_down", disp_val, 16'h0003);
        btn(EQ);
        chk("browse_load", disp_val, 16'h0003);
        press(4'h4);
        chk("loaded_full", disp_val, 16'h0003);
        press(4'hE);
        keys(32'h1D0, 3);
        run(16'h0001, 16'h0000, 2'd3, 1, 16'h0000, 1);
        chk("alu_err_flag", disp_err, 1);
        chk("alu_err_disp", disp_val, 0);
        press(4'hE);
        keys(32'h2A3, 3);
        exp_q.push_back('{16'h0002, 16'h0003, 2'd0});
        btn(EQ);
        rst = 0;
        #1;
        chk("mid_rst_start", alu_start, 0);
        chk("mid_rst_op", alu_op, 0);
        chk("mid_rst_a", alu_a, 0);
        chk("mid_rst_b", alu_b, 0);
        chk("mid_rst_disp", disp_val, 0);
        chk("mid_rst_err", disp_err, 0);
        chk("mid_rst_hist", hist_cnt, 0);
        @(negedge clk);
        rst = 1;
        alu_done = 1; alu_result = 16'h0055;
        @(negedge clk);
        alu_done = 0;
        chk("late_done_disp", disp_val, 0);
        chk("late_done_err", disp_err, 0);
        btn(EQ);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
